// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame controller.
// Holds the frame-state encoding, the error-code values reported on
// err_code_o, the default frame start byte and a length check helper.
package uart_pkg;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;
  localparam logic [2:0] ST_WRITE   = 3'd5;

  localparam logic [1:0] ERR_TIMEOUT = 2'b00;
  localparam logic [1:0] ERR_BAD_LEN = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  // A length byte is usable when it is in 1..max_len.
  function automatic logic len_ok(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file for uart_frame_ctrl.
// DEPTH x 8 storage with one synchronous write port and one asynchronous
// read port. Contents are not reset.
// Ports:
//   clk      - system clock
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - write byte
//   rd_addr  - read index
//   rd_data  - byte stored at rd_addr (combinational)
module uart_frame_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// UART frame controller.
// Parses frames of the form HEADER, addr, len, len payload bytes, checksum
// (XOR of addr, len and payload) from a byte stream, then issues one
// register write per payload byte to consecutive addresses starting at addr.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   rx_data_i    - received byte, valid when rx_valid_i pulses
//   wr_en_o      - write request, held with wr_addr_o/wr_data_o until
//                  wr_ready_i accepts it
//   frame_ok_o   - one-cycle pulse after the last write of a frame
//   frame_err_o  - one-cycle pulse on any frame error
//   err_code_o   - code of the most recent error (held)
//   busy_o       - controller is inside a frame
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       wr_en_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  input  logic       wr_ready_i,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]    state;
  logic [7:0]    base;
  logic [7:0]    csum;
  logic [4:0]    len;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    buf_rd;
  logic          timed;
  logic          tmo_hit;
  logic          last_idx;
  logic          buf_we;

  // Only the receive states are guarded by the inter-byte timeout.
  assign timed    = (state == ST_ADDR) || (state == ST_LEN) ||
                    (state == ST_PAYLOAD) || (state == ST_CSUM);
  // A byte arriving in the expiry cycle is still accepted.
  assign tmo_hit  = timed && !rx_valid_i && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign last_idx = (5'(idx) == len - 5'd1);
  assign buf_we   = (state == ST_PAYLOAD) && rx_valid_i;

  uart_frame_buf #(
    .DEPTH(MAX_LEN),
    .AW   (IW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (buf_we),
    .wr_addr(idx),
    .wr_data(rx_data_i),
    .rd_addr(idx),
    .rd_data(buf_rd)
  );

  // Write interface is driven straight from the WRITE state so the request
  // appears the cycle after the checksum byte and stays stable until taken.
  assign wr_en_o   = (state == ST_WRITE);
  assign wr_addr_o = wr_en_o ? base + 8'(idx) : 8'h00;
  assign wr_data_o = wr_en_o ? buf_rd : 8'h00;
  assign busy_o    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      base        <= '0;
      csum        <= '0;
      len         <= '0;
      idx         <= '0;
      tmo_cnt     <= '0;
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;
      err_code_o  <= ERR_TIMEOUT;
    end else begin
      frame_ok_o  <= 1'b0;
      frame_err_o <= 1'b0;

      // Counts idle cycles since the last byte; any byte or leaving the
      // receive states restarts it, which also covers state entry.
      if (timed && !rx_valid_i) tmo_cnt <= tmo_cnt + 1'b1;
      else                      tmo_cnt <= '0;

      if (tmo_hit) begin
        state       <= ST_IDLE;
        frame_err_o <= 1'b1;
        err_code_o  <= ERR_TIMEOUT;
        tmo_cnt     <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_valid_i && rx_data_i == HEADER) state <= ST_ADDR;
          end
          ST_ADDR: begin
            if (rx_valid_i) begin
              base  <= rx_data_i;
              csum  <= rx_data_i;
              state <= ST_LEN;
            end
          end
          ST_LEN: begin
            if (rx_valid_i) begin
              if (len_ok(rx_data_i, MAX_LEN)) begin
                len   <= rx_data_i[4:0];
                csum  <= csum ^ rx_data_i;
                idx   <= '0;
                state <= ST_PAYLOAD;
              end else begin
                frame_err_o <= 1'b1;
                err_code_o  <= ERR_BAD_LEN;
                state       <= ST_IDLE;
              end
            end
          end
          ST_PAYLOAD: begin
            if (rx_valid_i) begin
              csum <= csum ^ rx_data_i;
              idx  <= idx + 1'b1;
              if (last_idx) state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (rx_valid_i) begin
              if (rx_data_i == csum) begin
                idx   <= '0;
                state <= ST_WRITE;
              end else begin
                frame_err_o <= 1'b1;
                err_code_o  <= ERR_CSUM;
                state       <= ST_IDLE;
              end
            end
          end
          ST_WRITE: begin
            // Bytes arriving while writing are dropped but reported; the
            // write sequence is not disturbed.
            if (rx_valid_i) begin
              frame_err_o <= 1'b1;
              err_code_o  <= ERR_OVERRUN;
            end
            if (wr_ready_i) begin
              if (last_idx) begin
                frame_ok_o <= 1'b1;
                state      <= ST_IDLE;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl.
// Directed frame table, hand-written timeout/overrun/reset sequences and
// randomized frames checked against a frame-level reference model.
module tb_uart_frame_ctrl;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic       wr_en_o;
  logic [7:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       wr_ready_i;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;
  logic       busy_o;

  int vec_cnt = 0;
  int fail_cnt = 0;
  int cyc = 0;
  int byte_cyc = 0;
  int rdy_mode = 0;

  int          mon_ok = 0;
  int          mon_err = 0;
  int          mon_err_cyc = 0;
  logic [1:0]  mon_code = 2'b00;
  logic [15:0] wr_q[$];
  int          wrc_q[$];
  logic        prev_pend = 1'b0;
  logic [15:0] prev_wr = 16'h0;

  typedef struct packed {
    logic [3:0]        nbytes;
    logic [0:7][7:0]   bytes;
    logic [1:0]        rdy;
    logic [1:0]        nwr;
    logic [0:1][15:0]  wr;
    logic [1:0]        code;
    logic              ok;
    logic              err;
  } vec_t;

  vec_t vecs[8];

  uart_frame_ctrl #(
    .HEADER     (8'hA5),
    .MAX_LEN    (8),
    .TIMEOUT_CYC(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .wr_en_o    (wr_en_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .wr_ready_i (wr_ready_i),
    .frame_ok_o (frame_ok_o),
    .frame_err_o(frame_err_o),
    .err_code_o (err_code_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Observes outputs mid-cycle: logs accepted writes and pulses, and checks
  // that a stalled write request holds its address and data.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        checkOutput("wr_hold_en", int'(wr_en_o), 1);
        checkOutput("wr_hold_addr_data", int'({wr_addr_o, wr_data_o}), int'(prev_wr));
      end
      if (wr_en_o && wr_ready_i) begin
        wr_q.push_back({wr_addr_o, wr_data_o});
        wrc_q.push_back(cyc);
      end
      if (frame_ok_o) mon_ok++;
      if (frame_err_o) begin
        mon_err++;
        mon_err_cyc = cyc;
        mon_code = err_code_o;
      end
      prev_pend = wr_en_o && !wr_ready_i;
      prev_wr = {wr_addr_o, wr_data_o};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: wr_ready_i = 1'b1;
      1: wr_ready_i = ~wr_ready_i;
      2: wr_ready_i = 1'($urandom_range(0, 1));
      default: wr_ready_i = 1'b0;
    endcase
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data_i = b;
    rx_valid_i = 1'b1;
    byte_cyc = cyc;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy_o && n < 300) begin
      tick();
      n++;
    end
    if (busy_o) checkOutput({name, "_idle_timeout"}, int'(busy_o), 0);
    tick();
    tick();
  endtask

  task automatic checkResults(input string name, input int sw, input int so, input int se,
                              input logic [15:0] ew[$], input int eok, input int eerr,
                              input logic [1:0] ecode);
    int nwr = wr_q.size() - sw;
    checkOutput({name, "_nwr"}, nwr, ew.size());
    for (int i = 0; i < ew.size(); i++)
      if (i < nwr) checkOutput({name, "_wr"}, int'(wr_q[sw + i]), int'(ew[i]));
    checkOutput({name, "_ok"}, mon_ok - so, eok);
    checkOutput({name, "_err"}, mon_err - se, eerr);
    if (eerr > 0) checkOutput({name, "_pulse_code"}, int'(mon_code), int'(ecode));
    checkOutput({name, "_code"}, int'(err_code_o), int'(ecode));
    checkOutput({name, "_busy"}, int'(busy_o), 0);
  endtask

  task automatic runFrame(input string name, input logic [7:0] fb[$], input int glo,
                          input int ghi, input int mode, input logic [15:0] ew[$],
                          input int eok, input int eerr, input logic [1:0] ecode,
                          input logic consec);
    int sw = wr_q.size();
    int so = mon_ok;
    int se = mon_err;
    int last;
    rdy_mode = mode;
    for (int i = 0; i < fb.size(); i++) begin
      applyStimulus(fb[i]);
      if (i < fb.size() - 1) repeat ($urandom_range(ghi, glo)) tick();
    end
    last = byte_cyc;
    waitIdle(name);
    checkResults(name, sw, so, se, ew, eok, eerr, ecode);
    if (consec && ew.size() > 0 && wr_q.size() - sw >= ew.size()) begin
      checkOutput({name, "_latency"}, wrc_q[sw] - last, 1);
      for (int i = 1; i < ew.size(); i++)
        checkOutput({name, "_b2b"}, wrc_q[sw + i] - wrc_q[sw + i - 1], 1);
    end
  endtask

  initial begin
    logic [7:0]  fb[$];
    logic [15:0] ew[$];
    logic [1:0]  held;
    logic [7:0]  addr, b, cs;
    int          sw, so, se, tc, n, len, kind, eok, eerr;

    rst_n = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i = 8'h00;
    wr_ready_i = 1'b0;
    repeat (3) tick();
    checkOutput("rst_wr_en", int'(wr_en_o), 0);
    checkOutput("rst_wr_addr", int'(wr_addr_o), 0);
    checkOutput("rst_wr_data", int'(wr_data_o), 0);
    checkOutput("rst_ok", int'(frame_ok_o), 0);
    checkOutput("rst_err", int'(frame_err_o), 0);
    checkOutput("rst_code", int'(err_code_o), 0);
    checkOutput("rst_busy", int'(busy_o), 0);
    rst_n = 1'b1;
    tick();
    tick();

    vecs[0] = '{nbytes: 4'd6, bytes: {8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21, 8'h00, 8'h00},
                rdy: 2'd0, nwr: 2'd2, wr: {16'h1011, 16'h1122}, code: 2'b00, ok: 1'b1, err: 1'b0};
    vecs[1] = '{nbytes: 4'd6, bytes: {8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h00},
                rdy: 2'd1, nwr: 2'd2, wr: {16'hFFAA, 16'h00BB}, code: 2'b00, ok: 1'b1, err: 1'b0};
    vecs[2] = '{nbytes: 4'd3, bytes: {8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                rdy: 2'd0, nwr: 2'd0, wr: {16'h0, 16'h0}, code: 2'b01, ok: 1'b0, err: 1'b1};
    vecs[3] = '{nbytes: 4'd3, bytes: {8'hA5, 8'h10, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                rdy: 2'd0, nwr: 2'd0, wr: {16'h0, 16'h0}, code: 2'b01, ok: 1'b0, err: 1'b1};
    vecs[4] = '{nbytes: 4'd5, bytes: {8'hA5, 8'h10, 8'h01, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00},
                rdy: 2'd0, nwr: 2'd0, wr: {16'h0, 16'h0}, code: 2'b10, ok: 1'b0, err: 1'b1};
    vecs[5] = '{nbytes: 4'd5, bytes: {8'hA5, 8'h20, 8'h01, 8'h7E, 8'h5F, 8'h00, 8'h00, 8'h00},
                rdy: 2'd0, nwr: 2'd1, wr: {16'h207E, 16'h0}, code: 2'b10, ok: 1'b1, err: 1'b0};
    vecs[6] = '{nbytes: 4'd6, bytes: {8'h3C, 8'hA5, 8'h05, 8'h01, 8'h99, 8'h9D, 8'h00, 8'h00},
                rdy: 2'd2, nwr: 2'd1, wr: {16'h0599, 16'h0}, code: 2'b10, ok: 1'b1, err: 1'b0};
    vecs[7] = '{nbytes: 4'd5, bytes: {8'hA5, 8'hA5, 8'h01, 8'hA5, 8'h01, 8'h00, 8'h00, 8'h00},
                rdy: 2'd0, nwr: 2'd1, wr: {16'hA5A5, 16'h0}, code: 2'b10, ok: 1'b1, err: 1'b0};

    for (int v = 0; v < 8; v++) begin
      fb.delete();
      ew.delete();
      for (int i = 0; i < int'(vecs[v].nbytes); i++) fb.push_back(vecs[v].bytes[i]);
      for (int i = 0; i < int'(vecs[v].nwr); i++) ew.push_back(vecs[v].wr[i]);
      runFrame($sformatf("vec%0d", v), fb, 0, 0, int'(vecs[v].rdy), ew, int'(vecs[v].ok),
               int'(vecs[v].err), vecs[v].code, vecs[v].rdy == 2'd0);
    end

    // Timeout while waiting for the length byte.
    rdy_mode = 0;
    se = mon_err;
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    tc = byte_cyc;
    n = 0;
    while (mon_err == se && n < T + 20) begin
      tick();
      n++;
    end
    tick();
    checkOutput("tmo_len_err", mon_err - se, 1);
    checkOutput("tmo_len_cycle", mon_err_cyc - tc, T + 1);
    checkOutput("tmo_len_code", int'(err_code_o), 0);
    checkOutput("tmo_len_busy", int'(busy_o), 0);

    // Timeout inside the payload, after an error that left a nonzero code.
    fb = '{8'hA5, 8'h10, 8'h00};
    ew.delete();
    runFrame("pre_tmo_pl", fb, 0, 0, 0, ew, 0, 1, 2'b01, 1'b0);
    se = mon_err;
    applyStimulus(8'hA5);
    applyStimulus(8'h10);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    tc = byte_cyc;
    n = 0;
    while (mon_err == se && n < T + 20) begin
      tick();
      n++;
    end
    tick();
    checkOutput("tmo_pl_err", mon_err - se, 1);
    checkOutput("tmo_pl_cycle", mon_err_cyc - tc, T + 1);
    checkOutput("tmo_pl_code", int'(err_code_o), 0);

    // Every byte lands exactly on the timeout cycle: no error.
    fb = '{8'hA5, 8'h10, 8'h01, 8'h77, 8'h66};
    ew = '{16'h1077};
    runFrame("tmo_exact", fb, T - 1, T - 1, 0, ew, 1, 0, 2'b00, 1'b0);

    // Overrun during a stalled write, stall longer than the timeout.
    sw = wr_q.size();
    so = mon_ok;
    se = mon_err;
    rdy_mode = 3;
    fb = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    foreach (fb[i]) applyStimulus(fb[i]);
    repeat (3) tick();
    applyStimulus(8'h5A);
    repeat (T + 20) tick();
    checkOutput("ovr_err_during", mon_err - se, 1);
    checkOutput("ovr_code_during", int'(err_code_o), 3);
    checkOutput("ovr_no_write_yet", wr_q.size() - sw, 0);
    checkOutput("ovr_busy", int'(busy_o), 1);
    checkOutput("ovr_wr_en", int'(wr_en_o), 1);
    rdy_mode = 0;
    waitIdle("ovr");
    ew = '{16'h1011, 16'h1122};
    checkResults("ovr", sw, so, se, ew, 1, 1, 2'b11);

    // Reset in the middle of a frame.
    so = mon_ok;
    se = mon_err;
    fb = '{8'hA5, 8'h10, 8'h03, 8'h11};
    foreach (fb[i]) applyStimulus(fb[i]);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", int'(busy_o), 0);
    checkOutput("rst_mid_code", int'(err_code_o), 0);
    checkOutput("rst_mid_err", int'(frame_err_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("rst_mid_no_ok", mon_ok - so, 0);
    checkOutput("rst_mid_no_err", mon_err - se, 0);
    fb = '{8'hA5, 8'h40, 8'h01, 8'h99, 8'hD8};
    ew = '{16'h4099};
    runFrame("after_rst", fb, 0, 0, 0, ew, 1, 0, 2'b00, 1'b1);

    // Reset while a write is pending.
    fb = '{8'hA5, 8'h10, 8'h00};
    ew.delete();
    runFrame("pre_rst_wr", fb, 0, 0, 0, ew, 0, 1, 2'b01, 1'b0);
    rdy_mode = 3;
    fb = '{8'hA5, 8'h30, 8'h01, 8'h44, 8'h75};
    foreach (fb[i]) applyStimulus(fb[i]);
    checkOutput("rst_wr_pending_en", int'(wr_en_o), 1);
    checkOutput("rst_wr_pending_addr_data", int'({wr_addr_o, wr_data_o}), 16'h3044);
    so = mon_ok;
    se = mon_err;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_en_cleared", int'(wr_en_o), 0);
    checkOutput("rst_wr_addr_cleared", int'(wr_addr_o), 0);
    checkOutput("rst_wr_data_cleared", int'(wr_data_o), 0);
    checkOutput("rst_wr_code_cleared", int'(err_code_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    rdy_mode = 0;
    repeat (5) tick();
    checkOutput("rst_wr_no_ok", mon_ok - so, 0);
    checkOutput("rst_wr_no_err", mon_err - se, 0);
    checkOutput("rst_wr_busy", int'(busy_o), 0);

    // Randomized frames against the frame-level model.
    held = 2'b00;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 5);
      fb.delete();
      ew.delete();
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        fb.push_back(b);
      end
      addr = 8'($urandom);
      fb.push_back(8'hA5);
      fb.push_back(addr);
      if (kind == 5) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(9, 255);
        fb.push_back(8'(len));
        eok = 0;
        eerr = 1;
        held = 2'b01;
      end else begin
        len = $urandom_range(1, 8);
        fb.push_back(8'(len));
        cs = addr ^ 8'(len);
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          fb.push_back(b);
          cs = cs ^ b;
          ew.push_back({8'(int'(addr) + i), b});
        end
        if (kind == 4) begin
          fb.push_back(cs ^ 8'($urandom_range(1, 255)));
          ew.delete();
          eok = 0;
          eerr = 1;
          held = 2'b10;
        end else begin
          fb.push_back(cs);
          eok = 1;
          eerr = 0;
        end
      end
      runFrame($sformatf("rnd%0d", f), fb, 0, ($urandom_range(0, 3) == 0) ? T - 1 : 2,
               $urandom_range(0, 2), ew, eok, eerr, held, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 SHALL have parameter HEADER, default 8'hA5, frame start byte.
REQ-002 SHALL have parameter MAX_LEN, default 8, maximum payload bytes per frame (1..16).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, allowed inter-byte gap in clk cycles.
REQ-004 SHALL have port clk  in  1  system clock, all logic on posedge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port rx_data_i  in  8  received byte from UART receiver.
REQ-007 SHALL have port rx_valid_i  in  1  one-cycle pulse, rx_data_i valid.
REQ-008 SHALL have port wr_en_o  out  1  register-write request.
REQ-009 SHALL have port wr_addr_o  out  8  write address.
REQ-010 SHALL have port wr_data_o  out  8  write data.
REQ-011 SHALL have port wr_ready_i  in  1  write accepted when wr_en_o && wr_ready_i.
REQ-012 SHALL have port frame_ok_o  out  1  one-cycle pulse, frame fully written.
REQ-013 SHALL have port frame_err_o  out  1  one-cycle pulse, frame error.
REQ-014 SHALL have port err_code_o  out  2  last error: 00 timeout, 01 bad length, 10 checksum, 11 overrun.
REQ-015 SHALL have port busy_o  out  1  high whenever state != IDLE.

Function
REQ-016 SHALL implement states IDLE, ADDR, LEN, PAYLOAD, CSUM, WRITE; frame = HEADER, addr, len, len payload bytes, checksum.
REQ-017 IDLE: SHALL go to ADDR on rx_valid_i with rx_data_i==HEADER; all other bytes discarded silently.
REQ-018 ADDR: on byte, SHALL latch base address, set csum=byte, go to LEN.
REQ-019 LEN: byte in 1..MAX_LEN SHALL be latched, csum^=byte, idx=0, go to PAYLOAD; else SHALL pulse frame_err_o, err_code_o=01, go to IDLE.
REQ-020 PAYLOAD: each byte SHALL be stored at buf[idx], csum^=byte, idx++; after byte idx==len-1 SHALL go to CSUM.
REQ-021 CSUM: byte==csum SHALL go to WRITE with idx=0; mismatch SHALL pulse frame_err_o, err_code_o=10, go to IDLE.
REQ-022 HEADER value received in ADDR..CSUM SHALL be treated as ordinary data (no resync).
REQ-023 WRITE: wr_en_o SHALL assert the cycle after the checksum byte, wr_addr_o=base+idx (8-bit wrap, 8'hFF+1=8'h00), wr_data_o=buf[idx].
REQ-024 wr_en_o/addr/data SHALL hold stable until accepted; each acceptance SHALL advance idx; no write cycle lost or repeated under any wr_ready_i pattern.
REQ-025 After last acceptance SHALL deassert wr_en_o next cycle, pulse frame_ok_o that cycle, return to IDLE.
REQ-026 rx_valid_i during WRITE: byte SHALL be dropped, frame_err_o pulsed, err_code_o=11; write sequence SHALL continue.
REQ-027 Timeout: in ADDR, LEN, PAYLOAD, CSUM a counter SHALL count cycles since last accepted byte; reaching TIMEOUT_CYC SHALL pulse frame_err_o, err_code_o=00, go to IDLE.
REQ-028 Timeout counter SHALL clear on state entry and on every rx_valid_i; rx_valid_i in the timeout cycle SHALL win (byte processed, no error).
REQ-029 No timeout SHALL apply in IDLE or WRITE.
REQ-030 err_code_o SHALL be registered and held until the next error.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE and all outputs 0 (err_code_o=00), counters 0.
REQ-032 Reset mid-frame or mid-WRITE SHALL abandon the frame with no frame_ok_o/frame_err_o pulse; payload buffer contents need not reset.

Structure
REQ-033 State encoding, err-code constants and HEADER default SHALL live in shared package uart_pkg.
REQ-034 Payload storage SHALL be sub-module uart_frame_buf (MAX_LEN x 8 register file, one write, one async read port).

Verification
REQ-035 A5 10 02 11 22 21, wr_ready_i=1 -> writes (10,11),(11,22) on consecutive cycles, frame_ok_o pulse, busy_o low after.
REQ-036 A5 FF 02 AA BB (FF^02^AA^BB) with wr_ready_i toggling 0/1 -> writes (FF,AA),(00,BB) each once, frame_ok_o.
REQ-037 A5 10 00 -> frame_err_o, err_code_o=01; A5 10 09 (MAX_LEN=8) -> same; no wr_en_o.
REQ-038 A5 10 01 55 00 -> frame_err_o, err_code_o=10, no wr_en_o; following valid frame accepted normally.
REQ-039 A5 10, then gap of TIMEOUT_CYC cycles -> frame_err_o, err_code_o=00; byte at cycle TIMEOUT_CYC exactly -> no error.
REQ-040 Byte during WRITE with wr_ready_i=0 -> frame_err_o, err_code_o=11, original writes complete, frame_ok_o.
